// File: rtl/neopixel_strand_decoder_if.sv
// Bus between the NeoPixel strand decoder and whatever consumes its pixels.
// The master side (the decoder) samples the raw strand line and reports pixels and frame status.
interface neopixel_strand_decoder_if;
  logic        neo_in;
  logic [23:0] pixel_color;
  logic [2:0]  pixel_index;
  logic        pixel_valid;
  logic        frame_done;
  logic [2:0]  pixel_count;
  logic        overflow;
  logic        proto_err;

  modport master (
    input  neo_in,
    output pixel_color, pixel_index, pixel_valid, frame_done,
           pixel_count, overflow, proto_err
  );

  modport slave (
    output neo_in,
    input  pixel_color, pixel_index, pixel_valid, frame_done,
           pixel_count, overflow, proto_err
  );
endinterface

// File: rtl/neopixel_strand_decoder.sv
// WS2812-style strand receiver: times each high pulse to recover GRB bits, packs them
// into 24-bit pixels, counts pixels per frame and detects the long-low latch.
module neopixel_strand_decoder #(
  parameter int NUM_PIXELS   = 5,
  parameter int MIN_HIGH     = 8,
  parameter int BIT1_THRESH  = 26,
  parameter int MAX_HIGH     = 50,
  parameter int LATCH_CYCLES = 2500
) (
  input  logic                       clock,
  input  logic                       reset,
  neopixel_strand_decoder_if.master  bus
);

  localparam logic [5:0]  MIN_HI  = 6'(MIN_HIGH);
  localparam logic [5:0]  BIT1_HI = 6'(BIT1_THRESH);
  localparam logic [5:0]  MAX_HI  = 6'(MAX_HIGH);
  localparam logic [11:0] LAT_Q   = 12'(LATCH_CYCLES);
  localparam logic [11:0] LAT_M1  = 12'(LATCH_CYCLES - 1);
  localparam logic [2:0]  NUM_Q   = 3'(NUM_PIXELS);

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_ERR
  } state_t;

  state_t      state, state_n;
  logic        sync1, sync2, line_dly;
  logic        rise, fall, line;
  logic [5:0]  hi_cnt, hi_cnt_n;
  logic [11:0] lo_cnt, lo_cnt_n, lo_inc;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [23:0] shift_reg, shift_n;
  logic [2:0]  pix_ctr, pix_ctr_n;
  logic        pix_pend, pix_pend_n;
  logic [23:0] color_q, color_n;
  logic [2:0]  index_q, index_n;
  logic        valid_q, valid_n;
  logic        done_q, done_n;
  logic [2:0]  count_q, count_n;
  logic        ovf_q, ovf_n;
  logic        err_q, err_n;

  // Two-flop synchronizer plus one delay flop for edge detection on the async line
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      line_dly <= 1'b0;
    end else begin
      sync1    <= bus.neo_in;
      sync2    <= sync1;
      line_dly <= sync2;
    end
  end

  assign line   = sync2;
  assign rise   = sync2 & ~line_dly;
  assign fall   = ~sync2 & line_dly;
  assign lo_inc = (lo_cnt >= LAT_Q) ? LAT_Q : lo_cnt + 12'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_SYNC;
      hi_cnt    <= '0;
      lo_cnt    <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      pix_ctr   <= '0;
      pix_pend  <= 1'b0;
      color_q   <= '0;
      index_q   <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      hi_cnt    <= hi_cnt_n;
      lo_cnt    <= lo_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_n;
      pix_ctr   <= pix_ctr_n;
      pix_pend  <= pix_pend_n;
      color_q   <= color_n;
      index_q   <= index_n;
      valid_q   <= valid_n;
      done_q    <= done_n;
      count_q   <= count_n;
      ovf_q     <= ovf_n;
      err_q     <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    hi_cnt_n   = hi_cnt;
    lo_cnt_n   = lo_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift_reg;
    pix_ctr_n  = pix_ctr;
    pix_pend_n = 1'b0;
    color_n    = color_q;
    index_n    = index_q;
    valid_n    = 1'b0;
    done_n     = 1'b0;
    count_n    = count_q;
    ovf_n      = ovf_q;
    err_n      = err_q;

    // A pixel completed on the previous fall is published (or flagged as surplus) here
    if (pix_pend) begin
      if (pix_ctr == NUM_Q) begin
        ovf_n = 1'b1;
      end else begin
        valid_n   = 1'b1;
        color_n   = shift_reg;
        index_n   = pix_ctr;
        pix_ctr_n = pix_ctr + 3'd1;
      end
    end

    case (state)
      S_SYNC: begin
        if (line) begin
          lo_cnt_n = '0;
        end else if (lo_cnt >= LAT_M1) begin
          lo_cnt_n = lo_inc;
          state_n  = S_IDLE;
        end else begin
          lo_cnt_n = lo_inc;
        end
      end
      S_IDLE: begin
        // First rise of a frame also retires the previous frame's sticky flags
        if (rise) begin
          state_n  = S_HIGH;
          hi_cnt_n = 6'd1;
          ovf_n    = 1'b0;
          err_n    = 1'b0;
        end
      end
      S_HIGH: begin
        if (hi_cnt > MAX_HI) begin
          state_n = S_ERR;
        end else if (fall) begin
          if (hi_cnt < MIN_HI) begin
            state_n = S_ERR;
          end else begin
            shift_n  = {shift_reg[22:0], (hi_cnt >= BIT1_HI)};
            state_n  = S_LOW;
            lo_cnt_n = 12'd1;
            if (bit_cnt == 5'd23) begin
              bit_cnt_n  = '0;
              pix_pend_n = 1'b1;
            end else begin
              bit_cnt_n = bit_cnt + 5'd1;
            end
          end
        end else begin
          hi_cnt_n = (hi_cnt == 6'h3f) ? hi_cnt : hi_cnt + 6'd1;
        end
      end
      S_LOW: begin
        if (rise) begin
          state_n  = S_HIGH;
          hi_cnt_n = 6'd1;
        end else if (lo_cnt >= LAT_M1) begin
          lo_cnt_n  = lo_inc;
          state_n   = S_IDLE;
          done_n    = 1'b1;
          count_n   = (pix_ctr > NUM_Q) ? NUM_Q : pix_ctr;
          err_n     = err_q | (bit_cnt != 5'd0);
          bit_cnt_n = '0;
          pix_ctr_n = '0;
        end else begin
          lo_cnt_n = lo_inc;
        end
      end
      S_ERR: begin
        err_n      = 1'b1;
        bit_cnt_n  = '0;
        pix_ctr_n  = '0;
        pix_pend_n = 1'b0;
        lo_cnt_n   = '0;
        state_n    = S_SYNC;
      end
      default: begin
        state_n = S_SYNC;
      end
    endcase
  end

  assign bus.pixel_color = color_q;
  assign bus.pixel_index = index_q;
  assign bus.pixel_valid = valid_q;
  assign bus.frame_done  = done_q;
  assign bus.pixel_count = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.proto_err   = err_q;

endmodule

// File: tb/tb_neopixel_strand_decoder.sv
// Scoreboard bench for neopixel_strand_decoder: directed strand waveforms push expected
// pixel/frame events, a monitor pops and compares whenever the decoder pulses an output.
module tb_neopixel_strand_decoder;

  logic clock = 1'b0;
  logic reset;

  neopixel_strand_decoder_if bus();

  neopixel_strand_decoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_frame;
    logic [23:0] color;
    logic [2:0]  idx;
    logic [2:0]  cnt;
    bit          ovf;
    bit          err;
    bit          err_dc;
  } exp_t;

  // kind 0: all outputs zero, 1: proto_err equals val, 2: scoreboard drained
  typedef struct {
    int kind;
    bit val;
  } probe_t;

  exp_t   exp_q[$];
  probe_t probe_q[$];
  int     checks = 0;
  int     passed = 0;

  task automatic expect_pixel(input logic [23:0] c, input logic [2:0] i);
    exp_t e;
    e = '{is_frame: 1'b0, color: c, idx: i, cnt: 3'd0, ovf: 1'b0, err: 1'b0, err_dc: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic expect_frame(input logic [2:0] n, input bit o, input bit er, input bit dc);
    exp_t e;
    e = '{is_frame: 1'b1, color: 24'd0, idx: 3'd0, cnt: n, ovf: o, err: er, err_dc: dc};
    exp_q.push_back(e);
  endtask

  task automatic probe(input int k, input bit v);
    probe_t p;
    p = '{kind: k, val: v};
    probe_q.push_back(p);
  endtask

  task automatic send_bit_w(input int hi, input int lo);
    bus.neo_in = 1'b1;
    repeat (hi) @(negedge clock);
    bus.neo_in = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  task automatic send_bit(input bit b);
    if (b) send_bit_w(35, 27);
    else   send_bit_w(18, 44);
  endtask

  task automatic send_pixel(input logic [23:0] c);
    for (int i = 23; i >= 0; i--) send_bit(c[i]);
  endtask

  task automatic hold_low(input int n);
    bus.neo_in = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  // Monitor: compares every output pulse against the scoreboard, then services probes
  initial begin
    exp_t   e;
    probe_t p;
    forever begin
      @(negedge clock);
      if (bus.pixel_valid && bus.frame_done) begin
        checks++;
        $display("[TB] FAIL pulse_overlap: pixel_valid=1 frame_done=1, required never both");
      end else if (bus.pixel_valid || bus.frame_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL unexpected_pulse: pixel_valid=%0b frame_done=%0b idx=%0d count=%0d, required no pulse",
                   bus.pixel_valid, bus.frame_done, bus.pixel_index, bus.pixel_count);
        end else begin
          e = exp_q.pop_front();
          if (bus.pixel_valid) begin
            if (!e.is_frame && bus.pixel_color == e.color && bus.pixel_index == e.idx)
              passed++;
            else
              $display("[TB] FAIL pixel: got color=%06h idx=%0d, required %s color=%06h idx=%0d",
                       bus.pixel_color, bus.pixel_index, e.is_frame ? "frame_done" : "pixel",
                       e.color, e.idx);
          end else begin
            if (e.is_frame && bus.pixel_count == e.cnt && bus.overflow == e.ovf &&
                (e.err_dc || bus.proto_err == e.err))
              passed++;
            else
              $display("[TB] FAIL frame: got count=%0d ovf=%0b err=%0b, required %s count=%0d ovf=%0b err=%0b",
                       bus.pixel_count, bus.overflow, bus.proto_err,
                       e.is_frame ? "frame_done" : "pixel", e.cnt, e.ovf, e.err);
          end
        end
      end
      if (probe_q.size() != 0) begin
        p = probe_q.pop_front();
        checks++;
        case (p.kind)
          0: begin
            if ({bus.pixel_color, bus.pixel_index, bus.pixel_valid, bus.frame_done,
                 bus.pixel_count, bus.overflow, bus.proto_err} == 34'd0)
              passed++;
            else
              $display("[TB] FAIL reset_outputs: got color=%06h idx=%0d valid=%0b done=%0b count=%0d ovf=%0b err=%0b, required all 0",
                       bus.pixel_color, bus.pixel_index, bus.pixel_valid, bus.frame_done,
                       bus.pixel_count, bus.overflow, bus.proto_err);
          end
          1: begin
            if (bus.proto_err == p.val) passed++;
            else $display("[TB] FAIL proto_err: got %0b, required %0b", bus.proto_err, p.val);
          end
          default: begin
            if (exp_q.size() == 0) passed++;
            else $display("[TB] FAIL drain: %0d expected events never seen, required 0", exp_q.size());
          end
        endcase
      end
    end
  end

  initial begin
    logic [23:0] c;
    reset      = 1'b0;
    bus.neo_in = 1'b0;
    #1;
    probe(0, 1'b0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    hold_low(2600);

    $display("[TB] single pixel frame");
    expect_pixel(24'hA53C0F, 3'd0);
    expect_frame(3'd1, 1'b0, 1'b0, 1'b0);
    send_pixel(24'hA53C0F);
    hold_low(2600);

    $display("[TB] full strand of five pixels");
    for (int i = 0; i < 5; i++) expect_pixel(24'(i + 1), 3'(i));
    expect_frame(3'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_pixel(24'(i + 1));
    hold_low(2600);

    $display("[TB] six pixels overflow");
    for (int i = 0; i < 5; i++) expect_pixel(24'hF0_0000 | 24'(i), 3'(i));
    expect_frame(3'd5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_pixel(24'hF0_0000 | 24'(i));
    hold_low(2600);

    $display("[TB] partial pixel at latch");
    expect_frame(3'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) send_bit(i[0]);
    hold_low(2600);

    $display("[TB] repeat full strand, flags cleared");
    for (int i = 0; i < 5; i++) expect_pixel(24'(i + 1), 3'(i));
    expect_frame(3'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_pixel(24'(i + 1));
    hold_low(2600);

    $display("[TB] short glitch then resync");
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    send_bit_w(5, 40);
    probe(1, 1'b1);
    hold_low(2600);
    expect_pixel(24'h123456, 3'd0);
    expect_frame(3'd1, 1'b0, 1'b0, 1'b1);
    send_pixel(24'h123456);
    hold_low(2600);

    $display("[TB] over-long high then resync");
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    send_bit_w(60, 40);
    probe(1, 1'b1);
    hold_low(2600);
    expect_pixel(24'hC0FFEE, 3'd0);
    expect_frame(3'd1, 1'b0, 1'b0, 1'b1);
    send_pixel(24'hC0FFEE);
    hold_low(2600);

    // Widths 25/26/8/50 give 0/1/0/1; a 2499 low mid-pixel must not end the frame
    $display("[TB] boundary widths");
    c = 24'h5A5A5A;
    expect_pixel(c, 3'd0);
    expect_frame(3'd1, 1'b0, 1'b0, 1'b0);
    send_bit_w(25, 30);
    send_bit_w(26, 30);
    send_bit_w(8, 30);
    send_bit_w(50, 30);
    for (int i = 19; i >= 0; i--)
      send_bit_w(c[i] ? 35 : 18, (i == 10) ? 2499 : (i == 0) ? 2500 : (c[i] ? 27 : 44));
    send_bit_w(7, 40);
    probe(1, 1'b1);
    hold_low(2600);

    $display("[TB] reset mid-pixel");
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    bus.neo_in = 1'b1;
    repeat (10) @(negedge clock);
    reset      = 1'b0;
    bus.neo_in = 1'b0;
    #1;
    probe(0, 1'b0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    hold_low(2600);
    expect_pixel(24'h00FF00, 3'd0);
    expect_frame(3'd1, 1'b0, 1'b0, 1'b0);
    send_pixel(24'h00FF00);
    hold_low(2600);

    probe(2, 1'b0);
    repeat (5) @(negedge clock);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
